dmem_arbiter: RTL

Two-port arbiter that shares the single-port data memory between the core load/store path (port 0) and a debug/program-loader path (port 1). It issues at most one memory access per cycle and returns read data one cycle after grant, tagged to the port that was granted. Fixed priority goes to port 0, with a starvation counter that forces a port 1 grant after a bounded wait. The block sits between `core` / the loader and the data memory instance.

---
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core (port 0) and a debug/loader
// path (port 1): fixed priority to port 0, with a starvation counter that forces port 1.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [3:0]        p0_be,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [3:0]        p1_be,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        PRIO_P0 = 1'b0,
        PRIO_P1 = 1'b1
    } prio_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    prio_e       state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        rd_pend_q, rd_pend_d;
    logic        rd_owner_q, rd_owner_d;
    logic        gnt0_s, gnt1_s;

    // Grant decision; held off entirely while reset is asserted
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (p0_req && p1_req) begin
            if (state_q == PRIO_P1) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (p0_req) begin
            gnt0_s = 1'b1;
        end else if (p1_req) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Starvation counter and priority-state next-state logic
    always_comb begin
        starve_cnt_d = 4'd0;
        state_d      = state_q;
        if (p1_req && !gnt1_s) begin
            if (starve_cnt_q >= LIMIT) begin
                starve_cnt_d = LIMIT;
            end else begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end else begin
            starve_cnt_d = 4'd0;
        end
        // PRIO_P1 also ends when port 1 withdraws, since its counter has cleared
        case (state_q)
            PRIO_P0: begin
                if (starve_cnt_d == LIMIT) begin
                    state_d = PRIO_P1;
                end else begin
                    state_d = PRIO_P0;
                end
            end
            PRIO_P1: begin
                if (gnt1_s || !p1_req) begin
                    state_d = PRIO_P0;
                end else begin
                    state_d = PRIO_P1;
                end
            end
            default: state_d = PRIO_P0;
        endcase
    end

    // Memory request mux driven from the granted port
    always_comb begin
        mem_en    = gnt0_s | gnt1_s;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        mem_be    = 4'b0000;
        if (gnt0_s) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_be    = p0_be;
        end else if (gnt1_s) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_be    = p1_be;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
            mem_be    = 4'b0000;
        end
    end

    // Read-return bookkeeping captured at the grant edge
    always_comb begin
        rd_pend_d  = (gnt0_s | gnt1_s) & ~mem_we;
        rd_owner_d = gnt1_s;
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= PRIO_P0;
            starve_cnt_q <= 4'd0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign p0_gnt    = gnt0_s;
    assign p1_gnt    = gnt1_s;
    assign p0_rvalid = rd_pend_q & ~rd_owner_q;
    assign p1_rvalid = rd_pend_q & rd_owner_q;
    assign p0_rdata  = p0_rvalid ? mem_rdata : {DATA_W{1'b0}};
    assign p1_rdata  = p1_rvalid ? mem_rdata : {DATA_W{1'b0}};

endmodule
